// File: rtl/core_pkg.sv
// Shared fetch-path types: the IF->ID beat layout, the NOP bubble encoding
// and the state encoding of the IF/ID skid register.
package core_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instruction;
        logic [XLEN-1:0] pc_plus4;
    } fetch_beat_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } if_id_state_e;

endpackage

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a 2-entry skid buffer; the IF-side ready is
// registered so the stall path from ID never reaches back into fetch.
//
// state | meaning
// EMPTY | no valid beat; NOP bubble driven toward ID
// ONE   | main register valid, skid empty
// TWO   | main and skid valid; IF-side ready held low
module if_id_skid_reg #(
    parameter int                  XLEN     = core_pkg::XLEN,
    parameter logic [XLEN-1:0]     NOP_INST = core_pkg::NOP_INST
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [XLEN-1:0] in_pc_i,
    input  logic [XLEN-1:0] in_instruction_i,
    input  logic [XLEN-1:0] in_pc_plus4_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] out_pc_o,
    output logic [XLEN-1:0] out_instruction_o,
    output logic [XLEN-1:0] out_pc_plus4_o
);
    import core_pkg::*;

    if_id_state_e state_q, state_d;
    fetch_beat_t  main_q, main_d;
    fetch_beat_t  skid_q, skid_d;
    logic         in_ready_q, in_ready_d;

    fetch_beat_t  in_beat;
    logic         main_vld;
    logic         accept;
    logic         consume;

    assign in_beat  = '{pc: in_pc_i, instruction: in_instruction_i, pc_plus4: in_pc_plus4_i};
    assign main_vld = (state_q != EMPTY);
    assign accept   = in_valid_i & in_ready_q;
    assign consume  = main_vld & out_ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_d  = in_beat;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && consume) begin
                    main_d = in_beat;
                end else if (accept) begin
                    skid_d  = in_beat;
                    state_d = TWO;
                end else if (consume) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (consume) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // A redirect drops everything, including a beat accepted this cycle;
        // main keeps its old payload so the invalid pc outputs stay quiet.
        if (flush_i) begin
            state_d = EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
        in_ready_d = (state_d != TWO);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready_o        = in_ready_q;
    assign out_valid_o       = main_vld;
    assign out_pc_o          = main_q.pc;
    assign out_pc_plus4_o    = main_q.pc_plus4;
    assign out_instruction_o = main_vld ? main_q.instruction : NOP_INST;

endmodule
